exe_stage_unit: RTL and testbench
=================================

Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM-subset pipeline; consumes the ID/EXE register outputs.
- Generates Val2 (shifter operand), runs the ALU and updates the NZCV status register.
- Computes the branch target and registers the results into the EXE/MEM pipeline register that feeds the memory stage.

Parameters:
- DATA_W, 32, datapath width (fixed 32; parameter for readability only)
- REG_ADDR_W, 4, register index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  memory-stage stall; holds the EXE/MEM register and status register
- pc_in  in  32  PC+4 of the instruction in EXE
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in  1 each  control bits from ID/EXE
- exe_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32  register operands
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  destination register
- branch_taken  out  1  combinational, = b_in; to IF and flush logic
- branch_addr  out  32  combinational branch target
- status_out  out  4  registered NZCV {N,Z,C,V}; to the ID condition check
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered
- alu_res_out, val_rm_out  out  32  registered
- dest_out  out  4  registered

Behaviour:
- Reset: all registered outputs and status_out are 0 while rst is high, asynchronously.
- Val2 selection:
  - If mem_r_en_in or mem_w_en_in: Val2 = zero-extend shift_operand_in[11:0].
  - Else if imm_in: Val2 = {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
  - Else: Val2 = val_rm_in shifted by shift_operand_in[11:7], type shift_operand_in[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes val_rm_in unchanged.
- ALU (exe_cmd_in):
  - 0001 MOV = Val2; 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2; 0011 ADC = Rn+Val2+C
  - 0100 SUB = Rn-Val2; 0101 SBC = Rn-Val2-!C
  - 0110 AND; 0111 ORR; 1000 EOR
  - Any other code: result 0, flags N/Z from that 0, C and V unchanged.
  - C and V come from the 33-bit add/sub only; logic ops and MOV/MVN keep the old C and V.
  - N = res[31]; Z = (res == 0).
  - C for SUB/SBC is NOT borrow (ARM convention).
  - V = operand signs equal and result sign differs, with the subtrahend inverted for SUB/SBC.
- Status register: on posedge clk, if s_in && !freeze, load the ALU flags. Otherwise hold. The value is visible on status_out from the next cycle.
- branch_addr = pc_in + (sign-extend(signed_imm_24_in) << 2), 32-bit wrap-around.
- EXE/MEM register: latency 1. On posedge clk with !freeze, capture wb_en, mem_r_en, mem_w_en, ALU result, val_rm_in and dest. With freeze, hold all.
- Simultaneous freeze and s_in: the status register does not update.
- Bubbles (all control bits 0) pass through as bubbles.
- Reset mid-stall: reset wins.

Optional Feature:
- Macro FORWARDING_EN.
- Defined:
  - Adds inputs sel_src1, sel_src2 (2 bits each) and fwd_mem_val, fwd_wb_val (32 bits each).
  - Select codes: 00 = ID value, 01 = fwd_mem_val, 10 = fwd_wb_val, 11 = ID value.
  - The Rn path is muxed before the ALU. The Rm path is muxed before both the Val2 shifter and val_rm_out (store data).
- Undefined: the ports are absent and operands come directly from the ID values.

Decomposition:
- Package exe_pkg:
  - ALU command codes EXE_MOV … EXE_EOR
  - Shift types SH_LSL/LSR/ASR/ROR
  - Flag bit indices FLAG_N/Z/C/V
- Sub-module val2_gen (combinational shifter/rotator) is natural.
- ALU and status/pipeline registers stay in exe_stage_unit.

Test Plan:
- ADD with s_in=1, Rn=0x7FFFFFFF, imm_in=1, shift_operand=0x001 -> alu_res_out=0x80000000 next cycle; status_out=1001 (N,V) after the edge.
- SUB with s_in=1, Rn=5, Rm=5, register operand LSL#0 -> result 0; status_out=0110 (Z,C).
- Immediate rotate: imm_in=1, shift_operand=0x4FF -> Val2=0xFF000000 (MOV) -> alu_res_out=0xFF000000.
- LDR: mem_r_en_in=1, Rn=0x100, shift_operand=0x004 -> alu_res_out=0x104, mem_r_en_out=1.
- Branch: b_in=1, pc_in=0x20, signed_imm_24=0xFFFFFE -> branch_taken=1, branch_addr=0x18 in the same cycle.
- freeze=1 with s_in=1 for 2 cycles -> all registered outputs and status_out unchanged. Assert rst mid-freeze -> all outputs 0 immediately.

Source files
------------

// File: rtl/exe_stage_unit_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types
// and NZCV flag bit positions.
package exe_pkg;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } alu_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_unit_val2_gen.sv
// Combinational second-operand generator: memory offset, rotated 8-bit
// immediate, or shifted/rotated register operand.
module val2_gen
  import exe_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [31:0] imm8;
  logic [4:0]  imm_rot;
  logic [4:0]  sh_amt;
  logic [5:0]  inv_amt;
  logic [5:0]  inv_rot;

  assign imm8    = {24'd0, shift_operand[7:0]};
  assign imm_rot = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];
  // Complementary shift distance for rotates; a distance of 32 shifts out to 0.
  assign inv_amt = 6'd32 - {1'b0, sh_amt};
  assign inv_rot = 6'd32 - {1'b0, imm_rot};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned (no latch).
  always_comb begin
    val2 = val_rm;
    if (mem_en) begin
      val2 = {20'd0, shift_operand};
    end else if (imm) begin
      val2 = (imm8 >> imm_rot) | (imm8 << inv_rot);
    end else if (sh_amt != 5'd0) begin
      case (sh_type_e'(shift_operand[6:5]))
        SH_LSL: val2 = val_rm << sh_amt;
        SH_LSR: val2 = val_rm >> sh_amt;
        SH_ASR: val2 = $unsigned($signed(val_rm) >>> sh_amt);
        SH_ROR: val2 = (val_rm >> sh_amt) | (val_rm << inv_amt);
        default: val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU with NZCV status register, branch
// target and the EXE/MEM pipeline register. Optional macro FORWARDING_EN adds
// operand forwarding muxes on the Rn and Rm paths.
module exe_stage_unit
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
`ifdef FORWARDING_EN
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [DATA_W-1:0]     fwd_mem_val,
  input  logic [DATA_W-1:0]     fwd_wb_val,
`endif
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  imm_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_addr,
  output logic [3:0]            status_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_flags;
  logic              c_new;
  logic              v_new;
  logic              arith;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   src1 = fwd_mem_val;
      2'b10:   src1 = fwd_wb_val;
      default: src1 = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   src2 = fwd_mem_val;
      2'b10:   src2 = fwd_wb_val;
      default: src2 = val_rm_in;
    endcase
  end
`else
  assign src1 = val_rn_in;
  assign src2 = val_rm_in;
`endif

  val2_gen u_val2_gen (
    .val_rm        (src2),
    .shift_operand (shift_operand_in),
    .imm           (imm_in),
    .mem_en        (mem_r_en_in | mem_w_en_in),
    .val2          (val2)
  );

  // Subtraction runs as Rn + ~Val2 + carry-in, so the carry out is NOT borrow.
  always_comb begin
    alu_res = '0;
    op_b    = val2;
    sum     = '0;
    arith   = 1'b0;
    case (alu_cmd_e'(exe_cmd_in))
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_ADD: begin
        arith = 1'b1;
        sum   = {1'b0, src1} + {1'b0, val2};
      end
      EXE_ADC: begin
        arith = 1'b1;
        sum   = {1'b0, src1} + {1'b0, val2} + {{DATA_W{1'b0}}, status_out[FLAG_C]};
      end
      EXE_SUB: begin
        arith = 1'b1;
        op_b  = ~val2;
        sum   = {1'b0, src1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
      end
      EXE_SBC: begin
        arith = 1'b1;
        op_b  = ~val2;
        sum   = {1'b0, src1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, status_out[FLAG_C]};
      end
      EXE_AND: alu_res = src1 & val2;
      EXE_ORR: alu_res = src1 | val2;
      EXE_EOR: alu_res = src1 ^ val2;
      default: alu_res = '0;
    endcase
    if (arith) alu_res = sum[DATA_W-1:0];
  end

  assign c_new = arith ? sum[DATA_W] : status_out[FLAG_C];
  assign v_new = arith ? ((src1[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != src1[DATA_W-1]))
                       : status_out[FLAG_V];

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = c_new;
    alu_flags[FLAG_V] = v_new;
  end

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_out <= '0;
    end else if (s_in && !freeze) begin
      status_out <= alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      alu_res_out  <= alu_res;
      val_rm_out   <= src2;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Self-checking bench for exe_stage_unit: arithmetic reference model checked
// every cycle plus directed vectors with hand-computed results.
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, val_rm_out;
  logic [3:0]  dest_out;

  int total = 0;
  int bad   = 0;

  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status_out(status_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res_out(alu_res_out),
    .val_rm_out(val_rm_out), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                         input logic imm, input logic mem);
    logic [63:0] t;
    int n;
    if (mem) return {20'd0, so};
    if (imm) begin
      t = {2{24'd0, so[7:0]}} >> (2 * so[11:8]);
      return t[31:0];
    end
    n = int'(so[11:7]);
    if (n == 0) return rm;
    case (so[6:5])
      2'd0: return rm << n;
      2'd1: return rm >> n;
      2'd2: begin t = {{32{rm[31]}}, rm} >> n; return t[31:0]; end
      default: begin t = {rm, rm} >> n; return t[31:0]; end
    endcase
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                input logic [31:0] v2, input logic [3:0] st,
                                output logic [31:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, cin, r, sr;
    logic c, v;
    ua = {32'd0, rn};  ub = {32'd0, v2};
    sa = {{32{rn[31]}}, rn};  sb = {{32{v2[31]}}, v2};
    cin = st[1] ? 64'd1 : 64'd0;
    c = st[1];  v = st[0];  r = 0;  sr = 0;
    case (cmd)
      4'd1: r = ub;
      4'd9: r = {32'd0, ~v2};
      4'd2, 4'd3: begin
        if (cmd == 4'd2) cin = 0;
        r = ua + ub + cin;  sr = sa + sb + cin;
        c = r > 64'hFFFF_FFFF;
        v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
      end
      4'd4, 4'd5: begin
        if (cmd == 4'd4) cin = 1;
        r = ua - ub - (1 - cin);  sr = sa - sb - (1 - cin);
        c = ua >= ub + (1 - cin);
        v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
      end
      4'd6: r = {32'd0, rn & v2};
      4'd7: r = {32'd0, rn | v2};
      4'd8: r = {32'd0, rn ^ v2};
      default: r = 0;
    endcase
    res = r[31:0];
    fl  = {res[31], res == 32'd0, c, v};
  endfunction

  logic [31:0] e_res, e_rm;
  logic [3:0]  e_st, e_dest;
  logic        e_wb, e_mr, e_mw;

  always @(posedge clk or posedge rst) begin
    logic [31:0] r;
    logic [3:0]  f;
    if (rst) begin
      e_res <= 0; e_rm <= 0; e_st <= 0; e_dest <= 0;
      e_wb <= 0; e_mr <= 0; e_mw <= 0;
    end else if (!freeze) begin
      m_alu(exe_cmd_in, val_rn_in,
            m_val2(val_rm_in, shift_operand_in, imm_in, mem_r_en_in | mem_w_en_in),
            e_st, r, f);
      e_res <= r; e_rm <= val_rm_in; e_dest <= dest_in;
      e_wb <= wb_en_in; e_mr <= mem_r_en_in; e_mw <= mem_w_en_in;
      if (s_in) e_st <= f;
    end
  end

  function automatic logic [31:0] m_baddr(input logic [31:0] pc, input logic [23:0] off);
    int o;
    o = int'(off);
    if (off[23]) o = o - (1 << 24);
    return pc + 32'(o * 4);
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("status", {28'd0, status_out}, {28'd0, e_st});
    check("alu_res", alu_res_out, e_res);
    check("val_rm", val_rm_out, e_rm);
    check("dest", {28'd0, dest_out}, {28'd0, e_dest});
    check("ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'd0, e_wb, e_mr, e_mw});
    check("b_taken", {31'd0, branch_taken}, {31'd0, b_in});
    check("b_addr", branch_addr, m_baddr(pc_in, signed_imm_24_in));
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    freeze = 0; pc_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    b_in = 0; s_in = 0; imm_in = 0; exe_cmd_in = 0; val_rn_in = 0; val_rm_in = 0;
    shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0;
  endtask

  task automatic alu(input logic [3:0] cmd, input logic s, input logic imm,
                     input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so);
    idle();
    wb_en_in = 1; exe_cmd_in = cmd; s_in = s; imm_in = imm;
    val_rn_in = rn; val_rm_in = rm; shift_operand_in = so; dest_in = 4'd3;
  endtask

  // Results of the vector applied before the call are visible after this.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic after();
    #1;
  endtask

  initial begin
    idle();
    #1 rst = 1;
    @(negedge clk);
    check("reset_res", alu_res_out, 32'd0);
    check("reset_st", {28'd0, status_out}, 32'd0);
    after(); rst = 0;

    alu(4'b0010, 1, 1, 32'h7FFF_FFFF, 32'd0, 12'h001);       // ADD imm 1
    cycle();
    check("add_res", alu_res_out, 32'h8000_0000);
    check("add_nv", {28'd0, status_out}, 32'b1001);
    after();

    alu(4'b0100, 1, 0, 32'd5, 32'd5, 12'h000);               // SUB 5-5
    cycle();
    check("sub_res", alu_res_out, 32'd0);
    check("sub_zc", {28'd0, status_out}, 32'b0110);
    after();

    alu(4'b0001, 0, 1, 32'd0, 32'd0, 12'h4FF);               // MOV rotated imm
    cycle();
    check("mov_rot", alu_res_out, 32'hFF00_0000);
    after();

    alu(4'b0010, 0, 0, 32'h100, 32'hDEAD_BEEF, 12'h004);     // LDR address
    wb_en_in = 1; mem_r_en_in = 1;
    cycle();
    check("ldr_addr", alu_res_out, 32'h104);
    check("ldr_ren", {31'd0, mem_r_en_out}, 32'd1);
    check("ldr_st_hold", {28'd0, status_out}, 32'b0110);
    after();

    idle(); b_in = 1; pc_in = 32'h20; signed_imm_24_in = 24'hFFFFFE;
    after();
    check("br_taken", {31'd0, branch_taken}, 32'd1);
    check("br_addr", branch_addr, 32'h18);
    cycle(); after();

    alu(4'b0011, 1, 0, 32'd1, 32'd2, 12'h080);               // ADC 1+(2<<1)+C
    cycle();
    check("adc_res", alu_res_out, 32'd6);
    check("adc_st", {28'd0, status_out}, 32'b0000);
    after();

    alu(4'b0101, 1, 0, 32'd10, 32'd3, 12'h000);              // SBC C=0
    cycle();
    check("sbc_res", alu_res_out, 32'd6);
    check("sbc_st", {28'd0, status_out}, 32'b0010);
    after();

    alu(4'b0001, 0, 0, 32'd0, 32'h8000_0000, 12'h240);       // MOV ASR#4
    cycle();
    check("asr", alu_res_out, 32'hF800_0000);
    after();

    alu(4'b0001, 0, 0, 32'd0, 32'h1234_5678, 12'h460);       // MOV ROR#8
    cycle();
    check("ror", alu_res_out, 32'h7812_3456);
    after();

    alu(4'b1001, 0, 0, 32'd0, 32'h0F0F_0000, 12'h0A0);       // MVN LSR#1
    cycle();
    check("mvn_lsr", alu_res_out, 32'hF878_7FFF);
    after();

    alu(4'b0100, 1, 0, 32'h8000_0000, 32'd1, 12'h000);       // SUB overflow
    cycle();
    check("subv_res", alu_res_out, 32'h7FFF_FFFF);
    check("subv_st", {28'd0, status_out}, 32'b0011);
    after();

    alu(4'b1000, 1, 0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 12'h000); // EOR keeps C,V
    cycle();
    check("eor_res", alu_res_out, 32'h0F0F_0F0F);
    check("eor_st", {28'd0, status_out}, 32'b0011);
    after();

    alu(4'b0110, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 12'h000); // AND
    cycle(); after();
    alu(4'b0111, 0, 0, 32'hFF00_0000, 32'h0000_00FF, 12'h000); // ORR
    cycle(); after();

    alu(4'b1111, 1, 0, 32'h1234, 32'h5678, 12'h000);         // unknown cmd
    cycle();
    check("unk_res", alu_res_out, 32'd0);
    check("unk_st", {28'd0, status_out}, 32'b0111);
    after();

    alu(4'b0010, 1, 0, 32'h7FFF_FFFF, 32'd1, 12'h000);       // frozen ADD
    freeze = 1; dest_in = 4'd9; mem_w_en_in = 1;
    cycle();
    check("frz_res", alu_res_out, 32'd0);
    check("frz_st", {28'd0, status_out}, 32'b0111);
    cycle();
    check("frz_res2", alu_res_out, 32'd0);
    check("frz_dest", {28'd0, dest_out}, 32'd3);
    #3 rst = 1;
    #1;
    check("rst_st", {28'd0, status_out}, 32'd0);
    check("rst_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
    check("rst_dest", {28'd0, dest_out}, 32'd0);
    cycle(); after();
    rst = 0;

    idle();                                                  // bubble
    cycle();
    check("bubble_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
    after();

    alu(4'b0010, 0, 0, 32'd0, 32'hCAFE_0001, 12'h000);       // store data path
    mem_w_en_in = 1; wb_en_in = 0; dest_in = 4'd12;
    cycle();
    check("st_data", val_rm_out, 32'hCAFE_0001);
    check("st_wen", {31'd0, mem_w_en_out}, 32'd1);
    after();
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
